// File: rtl/keyed_irq_arbiter.sv
// Keyed interrupt arbiter: serially loaded XOR key masks the requests and the output,
// sticky pending vector feeds a registered grant with fixed or round-robin priority.
module keyed_irq_arbiter #(
  parameter int NCH   = 9,
  parameter int RR    = 0,
  parameter int KEY_W = NCH + 1,
  parameter int IDW   = $clog2(NCH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NCH-1:0] irq_i,
  input  logic           key_load_i,
  input  logic           key_vld_i,
  input  logic           key_sdi_i,
  input  logic           gnt_ack_i,
  output logic           gnt_vld_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           irq_out_o,
  output logic           key_ready_o,
  output logic [NCH-1:0] pending_o
);

  localparam logic [1:0] ST_LOCKED = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam int CW = $clog2(KEY_W + 1);

  typedef logic [IDW-1:0] id_t;
  typedef logic [IDW:0]   idx_t;
  typedef logic [CW-1:0]  cnt_t;

  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  cnt_t             cnt_q, cnt_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic             gnt_vld_q, gnt_vld_d;
  id_t              gnt_id_q, gnt_id_d;
  id_t              rr_ptr_q, rr_ptr_d;
  logic             irq_out_q, irq_out_d;
  logic             key_ready_q, key_ready_d;
  logic [NCH-1:0]   req_eff_s, clr_s;
  id_t              sel_s;

  // First set bit of vec found by scanning upward from start, wrapping modulo NCH.
  function automatic id_t pick(input logic [NCH-1:0] vec, input id_t start);
    idx_t idx;
    pick = {IDW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = {1'b0, start} + idx_t'(i);
      if (idx >= idx_t'(NCH)) begin
        idx = idx - idx_t'(NCH);
      end else begin
        idx = idx;
      end
      if (vec[idx[IDW-1:0]]) begin
        pick = idx[IDW-1:0];
      end else begin
        pick = pick;
      end
    end
  endfunction

  // Request masking, ack clear mask and priority selection.
  always_comb begin
    req_eff_s = irq_i ^ key_q[NCH-1:0];
    if (gnt_vld_q && gnt_ack_i) begin
      clr_s = {{(NCH-1){1'b0}}, 1'b1} << gnt_id_q;
    end else begin
      clr_s = {NCH{1'b0}};
    end
    sel_s = pick(pend_q, (RR != 0) ? rr_ptr_q : {IDW{1'b0}});
  end

  // Next-state: key shift-in, pending update and grant handshake.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    gnt_vld_d = gnt_vld_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (key_load_i) begin
      state_d   = ST_SHIFT;
      cnt_d     = cnt_t'(0);
      pend_d    = {NCH{1'b0}};
      gnt_vld_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      pend_d    = {NCH{1'b0}};
      gnt_vld_d = 1'b0;
      if (key_vld_i) begin
        key_d = {key_sdi_i, key_q[KEY_W-1:1]};
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(KEY_W - 1)) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_SHIFT;
        end
      end else begin
        key_d = key_q;
      end
    end else begin
      pend_d = (pend_q & ~clr_s) | req_eff_s;
      if (gnt_vld_q) begin
        if (gnt_ack_i) begin
          gnt_vld_d = 1'b0;
          rr_ptr_d  = (gnt_id_q == id_t'(NCH - 1)) ? {IDW{1'b0}} : gnt_id_q + id_t'(1);
        end else begin
          gnt_vld_d = 1'b1;
        end
      end else if (|pend_q) begin
        gnt_vld_d = 1'b1;
        gnt_id_d  = sel_s;
      end else begin
        gnt_vld_d = 1'b0;
      end
    end
    irq_out_d   = gnt_vld_d ^ key_d[NCH];
    key_ready_d = (state_d == ST_ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_LOCKED;
      key_q       <= {KEY_W{1'b0}};
      cnt_q       <= cnt_t'(0);
      pend_q      <= {NCH{1'b0}};
      gnt_vld_q   <= 1'b0;
      gnt_id_q    <= {IDW{1'b0}};
      rr_ptr_q    <= {IDW{1'b0}};
      irq_out_q   <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      gnt_vld_q   <= gnt_vld_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      irq_out_q   <= irq_out_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign gnt_vld_o   = gnt_vld_q;
  assign gnt_id_o    = gnt_id_q;
  assign irq_out_o   = irq_out_q;
  assign key_ready_o = key_ready_q;
  assign pending_o   = pend_q;

endmodule

// File: tb/tb_keyed_irq_arbiter.sv
// Bench for keyed_irq_arbiter: a fixed-priority and a round-robin instance share the
// request/key inputs and are compared every cycle against a behavioural model.
module tb_keyed_irq_arbiter;

  localparam int NCH   = 9;
  localparam int KEY_W = NCH + 1;
  localparam int IDW   = $clog2(NCH);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NCH-1:0]            irq;
  logic                      key_load, key_vld, key_sdi;
  logic [1:0]                ack;
  logic [1:0]                gv_o, iout_o, kr_o;
  logic [1:0][IDW-1:0]       gid_o;
  logic [1:0][NCH-1:0]       pend_o;

  int total = 0;
  int bad   = 0;

  // model state, index 0 = fixed priority, 1 = round-robin
  int               mst[2];
  logic [KEY_W-1:0] mkey[2];
  int               mcnt[2];
  logic [NCH-1:0]   mpend[2];
  bit               mgv[2];
  int               mgid[2];
  int               mrr[2];
  int               grants[$];

  always #5 clk = ~clk;

  keyed_irq_arbiter #(.NCH(NCH), .RR(0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .key_load_i(key_load), .key_vld_i(key_vld),
    .key_sdi_i(key_sdi), .gnt_ack_i(ack[0]), .gnt_vld_o(gv_o[0]), .gnt_id_o(gid_o[0]),
    .irq_out_o(iout_o[0]), .key_ready_o(kr_o[0]), .pending_o(pend_o[0]));

  keyed_irq_arbiter #(.NCH(NCH), .RR(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .key_load_i(key_load), .key_vld_i(key_vld),
    .key_sdi_i(key_sdi), .gnt_ack_i(ack[1]), .gnt_vld_o(gv_o[1]), .gnt_id_o(gid_o[1]),
    .irq_out_o(iout_o[1]), .key_ready_o(kr_o[1]), .pending_o(pend_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int choose(input logic [NCH-1:0] p, input int start);
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (start + k) % NCH;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mst[m] = 0; mkey[m] = '0; mcnt[m] = 0; mpend[m] = '0;
      mgv[m] = 1'b0; mgid[m] = 0; mrr[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [NCH-1:0] clr, req, np;
      if (key_load) begin
        mst[m] = 1; mcnt[m] = 0; mpend[m] = '0; mgv[m] = 1'b0;
      end else if (mst[m] == 1) begin
        if (key_vld) begin
          mkey[m] = (mkey[m] >> 1) | (KEY_W'(key_sdi) << (KEY_W - 1));
          mcnt[m]++;
          if (mcnt[m] == KEY_W) mst[m] = 2;
        end
      end else begin
        clr = (mgv[m] && ack[m]) ? NCH'(1) << mgid[m] : '0;
        req = irq ^ mkey[m][NCH-1:0];
        np  = (mpend[m] & ~clr) | req;
        if (mgv[m]) begin
          if (ack[m]) begin
            mgv[m] = 1'b0;
            mrr[m] = (mgid[m] + 1) % NCH;
          end
        end else if (mpend[m] != 0) begin
          mgv[m]  = 1'b1;
          mgid[m] = choose(mpend[m], (m == 1) ? mrr[m] : 0);
        end
        mpend[m] = np;
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("gnt_vld[%0d]", m), 32'(gv_o[m]), 32'(mgv[m]));
      chk($sformatf("gnt_id[%0d]", m), 32'(gid_o[m]), 32'(mgid[m]));
      chk($sformatf("irq_out[%0d]", m), 32'(iout_o[m]), 32'(mgv[m] ^ mkey[m][NCH]));
      chk($sformatf("key_ready[%0d]", m), 32'(kr_o[m]), 32'(mst[m] == 2));
      chk($sformatf("pending[%0d]", m), 32'(pend_o[m]), 32'(mpend[m]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; key_load = 1'b0; key_vld = 1'b0; key_sdi = 1'b0; ack = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_irq_out", 32'(iout_o[0]), 32'd0);
    rst_n = 1'b1;

    // fixed/rr basic grants on ch 2 and ch 4
    irq = 9'h014; step();
    irq = 9'h000; step();
    chk("first_gnt", 32'(gid_o[0]), 32'd2);
    chk("first_vld", 32'(gv_o[0]), 32'd1);
    ack = 2'b11; step();
    chk("ack_drop", 32'(gv_o[0]), 32'd0);
    ack = 2'b00; step();
    chk("second_gnt", 32'(gid_o[0]), 32'd4);
    chk("second_gnt_rr", 32'(gid_o[1]), 32'd4);
    ack = 2'b11; step();
    ack = 2'b00; step();
    chk("drained", 32'(pend_o[0]), 32'd0);

    // load key 0x3FF with two stall cycles
    key_load = 1'b1; step();
    key_load = 1'b0; key_sdi = 1'b1; irq = 9'h1FE;
    for (int i = 0; i < 12; i++) begin
      key_vld = !(i == 3 || i == 7);
      step();
      chk("key_ready_timing", 32'(kr_o[0]), 32'(i == 11));
    end
    key_vld = 1'b0;
    chk("idle_irq_out_inv", 32'(iout_o[0]), 32'd1);
    step();
    step();
    chk("keyed_gnt", 32'(gid_o[0]), 32'd0);
    chk("keyed_irq_out", 32'(iout_o[0]), 32'd0);
    irq = 9'h1FF; ack = 2'b11; step();
    chk("keyed_irq_out_idle", 32'(iout_o[0]), 32'd1);
    ack = 2'b00;

    // back to zero key through reset, then round-robin sweep
    rst_n = 1'b0; model_reset(); #2; compare_all();
    @(posedge clk); #1; rst_n = 1'b1;
    irq = 9'h1FF;
    for (int c = 0; c < 26; c++) begin
      ack = {mgv[1], mgv[0]};
      if (mgv[1]) grants.push_back(mgid[1]);
      step();
    end
    chk("rr_count", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("rr_seq%0d", i), 32'(grants[i]), 32'(i % NCH));

    // drain, then re-request held through ack
    irq = '0;
    for (int c = 0; c < 40; c++) begin
      ack = {mgv[1], mgv[0]};
      step();
    end
    ack = 2'b00; step();
    irq = 9'h008; step();
    step();
    chk("ch3_gnt", 32'(gid_o[0]), 32'd3);
    ack = 2'b01; step();
    chk("ch3_sticky", 32'(pend_o[0][3]), 32'd1);
    ack = 2'b00; step();
    chk("ch3_regnt_vld", 32'(gv_o[0]), 32'd1);
    chk("ch3_regnt_id", 32'(gid_o[0]), 32'd3);
    irq = '0;

    // key_load during a grant, then reset mid-shift
    key_load = 1'b1; step();
    chk("kl_vld", 32'(gv_o[0]), 32'd0);
    chk("kl_pend", 32'(pend_o[0]), 32'd0);
    key_load = 1'b0; key_vld = 1'b1; key_sdi = 1'b1;
    repeat (5) step();
    key_vld = 1'b0;
    #3 rst_n = 1'b0; model_reset();
    #1 compare_all();
    chk("async_rst_ready", 32'(kr_o[1]), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      irq      = NCH'($urandom & $urandom);
      key_load = ($urandom_range(0, 39) == 0);
      key_vld  = ($urandom_range(0, 3) != 0);
      key_sdi  = 1'($urandom);
      ack[0]   = ($urandom_range(0, 2) != 0);
      ack[1]   = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
